beam_sum_tx: RTL and testbench

- Consumes the eight per-microphone delayed PCM streams from the delay stage.
- Sums enabled channels sequentially, one channel per clock, then normalises the result to one mono beamformed sample.
- Serialises the sample over a free-running I2S-style transmitter (mono, duplicated on left and right) toward the codec/host.
- Sits directly downstream of the delay stage, at the output end of the mic-array pipeline.

---
 rtl/beam_sum_tx.sv | 161 ++++++++++++++++
 tb/tb_beam_sum_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_sum_tx.sv
// Beamformer summing stage: sequential masked accumulate of NUM_CH channels, normalise, and
// serialise as mono I2S. Define BEAM_SUM_SAT_EN to saturate the raw sum instead of averaging.
module beam_sum_tx #(
  parameter int DATA_W   = 19,
  parameter int NUM_CH   = 8,
  parameter int OUT_W    = 24,
  parameter int BCLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] pcm_in,
  input  logic [NUM_CH-1:0]        channel_mask,
  output logic                     busy,
  output logic                     overrun,
  output logic [DATA_W-1:0]        sum_out,
  output logic                     sum_valid,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sd
);
  localparam int LG    = $clog2(NUM_CH);
  localparam int CW    = (LG > 0) ? LG : 1;
  localparam int ACC_W = DATA_W + LG;
  localparam int DIV_W = $clog2(BCLK_DIV);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_CH*DATA_W-1:0]       snap_pcm;
  logic [NUM_CH-1:0]              snap_mask;
  logic [NUM_CH-1:0][DATA_W-1:0]  terms;
  logic signed [DATA_W-1:0]       term_sel;
  logic [CW-1:0]                  ch_idx;
  logic signed [ACC_W-1:0]        acc, acc_nxt;
  logic [DATA_W-1:0]              norm, hold;
  logic                           last_ch, accept;

  // masked-out channels contribute zero so the adder runs every ACCUM cycle
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign terms[k] = snap_mask[k] ? snap_pcm[k*DATA_W +: DATA_W] : '0;
  end

  assign term_sel = terms[ch_idx];
  assign last_ch  = (ch_idx == CW'(NUM_CH-1));
  assign acc_nxt  = acc + ACC_W'(term_sel);
  assign busy     = (state != IDLE);

`ifdef BEAM_SUM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  always_comb begin
    if (acc_nxt > SAT_MAX)      norm = DATA_W'(SAT_MAX);
    else if (acc_nxt < SAT_MIN) norm = DATA_W'(SAT_MIN);
    else                        norm = DATA_W'(acc_nxt);
  end
`else
  always_comb begin
    norm = DATA_W'(acc_nxt >>> LG);
  end
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (sample_valid) begin
               accept    = 1'b1;
               state_nxt = ACCUM;
             end
      ACCUM: if (last_ch) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_pcm  <= '0;
      snap_mask <= '0;
      ch_idx    <= '0;
      acc       <= '0;
      sum_out   <= '0;
      hold      <= '0;
      sum_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (accept) begin
        snap_pcm  <= pcm_in;
        snap_mask <= channel_mask;
        acc       <= '0;
        ch_idx    <= '0;
      end else if (state == ACCUM) begin
        acc    <= acc_nxt;
        ch_idx <= ch_idx + CW'(1);
        if (last_ch) begin
          sum_out   <= norm;
          hold      <= norm;
          sum_valid <= 1'b1;
        end
      end
      if (sample_valid && busy) overrun <= 1'b1;
    end
  end

  // Free-running I2S transmitter; all serial outputs update on the bclk falling edge.
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt, bit_nxt;
  logic [OUT_W-1:0] tx_word, tx_sh, hold_word;
  logic             div_hit, bclk_fall;

  assign hold_word = OUT_W'(hold) << (OUT_W - DATA_W);
  assign div_hit   = (div_cnt == DIV_W'(BCLK_DIV-1));
  assign bclk_fall = div_hit && i2s_bclk;
  assign bit_nxt   = bit_cnt + 6'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sd    <= 1'b0;
      tx_word   <= '0;
      tx_sh     <= '0;
    end else begin
      if (div_hit) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt  <= div_cnt + DIV_W'(1);
      end
      if (bclk_fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[5];
        if (bit_nxt[4:0] == 5'd0) begin
          // slot 0 of each half is the one-bclk delay; the word reloads for the right half
          i2s_sd <= 1'b0;
          if (bit_nxt == 6'd0) begin
            tx_word <= hold_word;
            tx_sh   <= hold_word;
          end else begin
            tx_sh   <= tx_word;
          end
        end else if ({1'b0, bit_nxt[4:0]} <= 6'(OUT_W)) begin
          i2s_sd <= tx_sh[OUT_W-1];
          tx_sh  <= tx_sh << 1;
        end else begin
          i2s_sd <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_beam_sum_tx.sv
// Directed bench for beam_sum_tx: reset, averaging, sign/floor, masking, serialiser, overrun.
module tb_beam_sum_tx;
  localparam int DW  = 19;
  localparam int NCH = 8;
  localparam int OW  = 24;
  localparam int BD  = 4;
`ifdef BEAM_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample_valid = 1'b0;
  logic [NCH*DW-1:0] pcm_in = '0;
  logic [NCH-1:0]    channel_mask = '0;
  logic              busy, overrun, sum_valid, i2s_bclk, i2s_lrclk, i2s_sd;
  logic [DW-1:0]     sum_out;

  int n_cmp = 0;
  int n_bad = 0;

  beam_sum_tx #(.DATA_W(DW), .NUM_CH(NCH), .OUT_W(OW), .BCLK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .pcm_in(pcm_in),
    .channel_mask(channel_mask), .busy(busy), .overrun(overrun), .sum_out(sum_out),
    .sum_valid(sum_valid), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [NCH*DW-1:0] fill(input logic [DW-1:0] v);
    logic [NCH*DW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NCH*DW-1:0] one_ch(input int idx, input logic [DW-1:0] v);
    logic [NCH*DW-1:0] r;
    r = '0;
    r[idx*DW +: DW] = v;
    return r;
  endfunction

  // Pulse sample_valid in cycle n, record sum_valid/busy over n+1..n+10, value at n+9.
  task automatic run_sample(input logic [NCH*DW-1:0] p, input logic [NCH-1:0] m,
                            output logic [9:0] vpat, output logic [9:0] bpat,
                            output logic [DW-1:0] val);
    pcm_in = p; channel_mask = m; sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
    val = '0;
    for (int k = 1; k <= 10; k++) begin
      vpat[k-1] = sum_valid;
      bpat[k-1] = busy;
      if (k == 9) val = sum_out;
      if (k < 10) tick;
    end
  endtask

  // Record sd/lrclk at the next 64 bclk rising edges (slot 0..63).
  task automatic capture_frame(output logic [63:0] sdv, output logic [63:0] lrv,
                               output int first_rise, output bit to);
    int   slot;
    logic prev;
    slot = 0; prev = i2s_bclk; sdv = '0; lrv = '0; first_rise = -1; to = 1'b1;
    for (int t = 1; t <= 700; t++) begin
      tick;
      if (!prev && i2s_bclk) begin
        if (first_rise < 0) first_rise = t;
        sdv[slot] = i2s_sd;
        lrv[slot] = i2s_lrclk;
        slot++;
        if (slot == 64) begin
          to = 1'b0;
          break;
        end
      end
      prev = i2s_bclk;
    end
  endtask

  task automatic test_reset;
    logic [63:0] sdv, lrv;
    int          fr;
    bit          to;
    logic [DW+5:0] outs;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'($urandom);
      channel_mask = NCH'($urandom);
      for (int c = 0; c < NCH; c++) pcm_in[c*DW +: DW] = DW'($urandom);
      tick;
    end
    outs = {busy, overrun, sum_valid, i2s_bclk, i2s_lrclk, i2s_sd, sum_out};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    sample_valid = 1'b0;
    rst = 1'b1;
    capture_frame(sdv, lrv, fr, to);
    n_cmp++;
    if (fr !== BD) begin
      n_bad++; $display("FAIL first_bclk_rise: got %0d clk want %0d", fr, BD);
    end
    n_cmp++;
    if (to || sdv !== 64'h0) begin
      n_bad++; $display("FAIL first_frame_sd: got %h (timeout %0d) want 0", sdv, to);
    end
    n_cmp++;
    if (lrv !== {32'hFFFF_FFFF, 32'h0}) begin
      n_bad++; $display("FAIL first_frame_lrclk: got %h want ffffffff00000000", lrv);
    end
  endtask

  task automatic test_average;
    logic [9:0] vp, bp;
    logic [DW-1:0] v, e;
    logic [NCH*DW-1:0] ramp;
    run_sample(fill(DW'(1000)), 8'hFF, vp, bp, v);
    n_cmp++;
    if (vp !== 10'h100) begin
      n_bad++; $display("FAIL avg_valid_timing: got %b want %b", vp, 10'h100);
    end
    n_cmp++;
    if (bp !== 10'h1FF) begin
      n_bad++; $display("FAIL avg_busy_timing: got %b want %b", bp, 10'h1FF);
    end
    e = SAT ? DW'(8000) : DW'(1000);
    n_cmp++;
    if (v !== e) begin
      n_bad++; $display("FAIL avg_1000: got %0d want %0d", $signed(v), $signed(e));
    end
    for (int k = 0; k < NCH; k++) ramp[k*DW +: DW] = DW'(8*(k+1));
    run_sample(ramp, 8'hFF, vp, bp, v);
    e = SAT ? DW'(288) : DW'(36);
    n_cmp++;
    if (v !== e || vp !== 10'h100) begin
      n_bad++; $display("FAIL avg_ramp: got %0d valid %b want %0d", $signed(v), vp, $signed(e));
    end
  endtask

  task automatic test_sign_floor;
    logic [9:0] vp, bp;
    logic [DW-1:0] v, e;
    run_sample(fill(-19'sd5), 8'hFF, vp, bp, v);
    e = SAT ? -19'sd40 : -19'sd5;
    n_cmp++;
    if (v !== e) begin
      n_bad++; $display("FAIL neg_five: got %0d want %0d", $signed(v), $signed(e));
    end
    run_sample(one_ch(0, -19'sd1), 8'hFF, vp, bp, v);
    e = -19'sd1;
    n_cmp++;
    if (v !== e) begin
      n_bad++; $display("FAIL floor_neg1: got %0d want %0d", $signed(v), $signed(e));
    end
    run_sample(one_ch(3, DW'(7)), 8'hFF, vp, bp, v);
    e = SAT ? DW'(7) : DW'(0);
    n_cmp++;
    if (v !== e) begin
      n_bad++; $display("FAIL floor_pos7: got %0d want %0d", $signed(v), $signed(e));
    end
    run_sample(fill(DW'(262143)), 8'hFF, vp, bp, v);
    e = DW'(262143);
    n_cmp++;
    if (v !== e) begin
      n_bad++; $display("FAIL full_scale: got %0d want %0d", $signed(v), $signed(e));
    end
  endtask

  task automatic test_mask;
    logic [9:0] vp, bp;
    logic [DW-1:0] v, e;
    run_sample(fill(DW'(800)), 8'h0F, vp, bp, v);
    e = SAT ? DW'(3200) : DW'(400);
    n_cmp++;
    if (v !== e) begin
      n_bad++; $display("FAIL mask_0f: got %0d want %0d", $signed(v), $signed(e));
    end
    run_sample(fill(DW'(800)), 8'h00, vp, bp, v);
    n_cmp++;
    if (v !== DW'(0) || vp !== 10'h100) begin
      n_bad++; $display("FAIL mask_00: got %0d valid %b want 0 valid %b", $signed(v), vp, 10'h100);
    end
  endtask

  task automatic test_serialiser;
    logic [9:0] vp, bp;
    logic [DW-1:0] v;
    logic [63:0] sdv, lrv, exp_sd;
    logic [OW-1:0] w;
    logic prev_lr;
    int fr, sl;
    bit to, found;
    // all channels averaged in default build; channel 0 alone gives the same value at unity gain
    run_sample(fill(DW'(19'h40001)), SAT ? 8'h01 : 8'hFF, vp, bp, v);
    n_cmp++;
    if (v !== DW'(19'h40001)) begin
      n_bad++; $display("FAIL ser_sum: got %h want 40001", v);
    end
    found = 1'b0;
    prev_lr = i2s_lrclk;
    for (int t = 0; t < 1200; t++) begin
      tick;
      if (prev_lr && !i2s_lrclk) begin
        found = 1'b1;
        break;
      end
      prev_lr = i2s_lrclk;
    end
    capture_frame(sdv, lrv, fr, to);
    w = 24'h800020;
    for (int s = 0; s < 64; s++) begin
      sl = s % 32;
      exp_sd[s] = (sl >= 1 && sl <= OW) ? w[OW-sl] : 1'b0;
    end
    n_cmp++;
    if (!found || to || sdv !== exp_sd) begin
      n_bad++; $display("FAIL ser_sd: got %h want %h (sync %0d timeout %0d)", sdv, exp_sd, found, to);
    end
    n_cmp++;
    if (lrv !== {32'hFFFF_FFFF, 32'h0}) begin
      n_bad++; $display("FAIL ser_lrclk: got %h want ffffffff00000000", lrv);
    end
  endtask

  task automatic test_overrun;
    logic [9:0] vp, bp;
    logic [DW-1:0] v, e;
    logic sv9;
    pcm_in = fill(DW'(100)); channel_mask = 8'hFF; sample_valid = 1'b1;
    tick;                                   // n+1
    sample_valid = 1'b0;
    tick; tick; tick;                       // n+4
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++; $display("FAIL overrun_before: got %b want 0", overrun);
    end
    pcm_in = fill(DW'(3000)); sample_valid = 1'b1;
    tick;                                   // n+5
    sample_valid = 1'b0;
    tick; tick; tick; tick;                 // n+9
    sv9 = sum_valid;
    e = SAT ? DW'(800) : DW'(100);
    n_cmp++;
    if (sv9 !== 1'b1 || sum_out !== e) begin
      n_bad++; $display("FAIL overrun_first_set: got %0d valid %b want %0d valid 1", $signed(sum_out), sv9, $signed(e));
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    tick;                                   // n+10
    run_sample(fill(DW'(50)), 8'hFF, vp, bp, v);
    e = SAT ? DW'(400) : DW'(50);
    n_cmp++;
    if (v !== e || vp !== 10'h100) begin
      n_bad++; $display("FAIL accept_n10: got %0d valid %b want %0d", $signed(v), vp, $signed(e));
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  initial begin
    test_reset;
    test_average;
    test_sign_floor;
    test_mask;
    test_serialiser;
    test_overrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
